// File: rtl/frame_mux_pkg.sv
// Shared types for the frame arbiter/multiplexer: FSM states and arbitration mode encodings.
package frame_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: one-hot winner among req, searching upward from ptr (round-robin)
// or from index 0 (fixed priority), wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 5,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  winner
);

  logic [PW-1:0]  start;
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] win_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   low_rot;

  // Rotate so that index 'start' sits at bit 0, isolate the lowest set bit,
  // then rotate back; avoids a variable-indexed priority loop.
  always_comb begin
    start   = mode ? '0 : ptr;
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[N-1:0];
    low_rot = req_rot & (~req_rot + {{(N-1){1'b0}}, 1'b1});
    win_dbl = {low_rot, low_rot} << start;
    winner  = win_dbl[2*N-1:N];
  end

endmodule

// File: rtl/frame_arb_mux.sv
// Frame-granular arbiter/mux: grants one switch FIFO per frame, pops it word by word
// into a registered output stage with valid/ready flow control.
module frame_arb_mux
  import frame_mux_pkg::*;
#(
  parameter int unsigned NUM_SW_INST = 5,
  parameter int unsigned FRAME_WIDTH = 32,
  parameter int unsigned PRIO_MODE   = PRIO_RR
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SW_INST-1:0]             fifo_valid,
  input  logic [NUM_SW_INST-1:0]             fifo_last,
  input  logic [NUM_SW_INST*FRAME_WIDTH-1:0] frame_in,
  output logic [NUM_SW_INST-1:0]             rd_sel,
  output logic [FRAME_WIDTH-1:0]             frame_out,
  output logic                               frame_valid,
  output logic                               frame_last,
  input  logic                               out_ready,
  output logic [NUM_SW_INST-1:0]             grant
);

  localparam int unsigned   PW       = $clog2(NUM_SW_INST);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_SW_INST - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [NUM_SW_INST-1:0]  grant_d;
  logic [NUM_SW_INST-1:0]  arb_winner;
  logic [PW-1:0]           rr_ptr_q;
  logic [PW-1:0]           rr_ptr_d;
  logic [PW-1:0]           owner_idx;
  logic [FRAME_WIDTH-1:0]  own_word;
  logic                    own_valid;
  logic                    own_last;
  logic                    xfer;

  rr_arbiter #(
    .N  (NUM_SW_INST),
    .PW (PW)
  ) u_arb (
    .req    (fifo_valid),
    .ptr    (rr_ptr_q),
    .mode   (PRIO_MODE == PRIO_FIXED),
    .winner (arb_winner)
  );

  always_comb begin
    own_word  = '0;
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_SW_INST; i++) begin
      if (grant[i]) begin
        own_word  = own_word | frame_in[i*FRAME_WIDTH +: FRAME_WIDTH];
        owner_idx = PW'(i);
      end
    end
  end

  assign own_valid = |(fifo_valid & grant);
  assign own_last  = |(fifo_last & grant);

  // Output stage is free when empty or being drained this cycle.
  assign xfer   = (state_q == BUSY) && own_valid && (!frame_valid || out_ready);
  assign rd_sel = (xfer && !rst) ? grant : '0;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|fifo_valid) begin
          grant_d = arb_winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer && own_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_idx == LAST_IDX) ? '0 : owner_idx + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_out   <= '0;
      frame_last  <= 1'b0;
      frame_valid <= 1'b0;
    end else if (xfer) begin
      frame_out   <= own_word;
      frame_last  <= own_last;
      frame_valid <= 1'b1;
    end else if (frame_valid && out_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_arb_mux.sv
// Directed bench for frame_arb_mux: FIFO source model, output scoreboard and per-cycle invariants.
module tb_frame_arb_mux;

  localparam int unsigned N  = 5;
  localparam int unsigned FW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    fifo_valid, fifo_last, rd_sel, grant;
  logic [N*FW-1:0] frame_in;
  logic [FW-1:0]   frame_out;
  logic            frame_valid, frame_last, out_ready;

  logic [N-1:0]    fp_req, fp_rd_sel, fp_grant;
  logic [N*FW-1:0] fp_in;
  logic [FW-1:0]   fp_out;
  logic            fp_valid, fp_last, fp_ready;

  int checks = 0;
  int errors = 0;

  logic [FW:0]  src_mem [N][16];
  int           src_wr [N];
  int           src_rd [N];
  logic [N-1:0] hold;

  logic [FW:0]   exp_q[$];
  logic [FW:0]   acc_q[$];
  logic [N-1:0]  gl[$];
  logic [N-1:0]  rl[$];
  logic          vl[$];
  logic [FW-1:0] ol[$];
  logic [N-1:0]  fpl[$];
  int            pop_cnt, acc_cnt;

  always #5 clk = ~clk;

  frame_arb_mux #(.NUM_SW_INST(N), .FRAME_WIDTH(FW), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_last(fifo_last),
    .frame_in(frame_in), .rd_sel(rd_sel), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_last(frame_last), .out_ready(out_ready),
    .grant(grant)
  );

  frame_arb_mux #(.NUM_SW_INST(N), .FRAME_WIDTH(FW), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .fifo_valid(fp_req), .fifo_last(fp_req),
    .frame_in(fp_in), .rd_sel(fp_rd_sel), .frame_out(fp_out),
    .frame_valid(fp_valid), .frame_last(fp_last), .out_ready(fp_ready),
    .grant(fp_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [FW-1:0] w, input logic l);
    src_mem[s][src_wr[s]] = {l, w};
    src_wr[s]++;
  endtask

  function automatic logic all_empty();
    logic e = 1'b1;
    for (int i = 0; i < N; i++) if (src_rd[i] < src_wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        fifo_valid[i]        = !hold[i];
        fifo_last[i]         = src_mem[i][src_rd[i]][FW];
        frame_in[i*FW +: FW] = src_mem[i][src_rd[i]][FW-1:0];
      end else begin
        fifo_valid[i]        = 1'b0;
        fifo_last[i]         = 1'b0;
        frame_in[i*FW +: FW] = '0;
      end
    end
  endtask

  // One clock: present FIFO heads, sample at negedge, check invariants and
  // scoreboard, then retire the popped heads just after the rising edge.
  task automatic tick();
    logic [N-1:0] rs;
    logic [FW:0]  e;
    apply_inputs();
    @(negedge clk);
    rs = rd_sel;
    gl.push_back(grant);
    rl.push_back(rd_sel);
    vl.push_back(frame_valid);
    ol.push_back(frame_out);
    fpl.push_back(fp_grant);
    chk("rd_sel_onehot0", 64'($onehot0(rd_sel)), 64'd1);
    chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    chk("rd_sel_in_grant", 64'(rd_sel & ~grant), 64'd0);
    chk("fp_grant_only_src0", 64'(fp_grant & 5'b11110), 64'd0);
    if (rst) begin
      chk("rst_rd_sel", 64'(rd_sel), 64'd0);
      exp_q.delete();
      pop_cnt = acc_cnt;
    end else begin
      if (frame_valid && out_ready) begin
        acc_q.push_back({frame_last, frame_out});
        acc_cnt++;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_word", 64'({frame_last, frame_out}), 64'(e));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rs[i]) begin
          chk("pop_nonempty", 64'(src_rd[i] < src_wr[i]), 64'd1);
          exp_q.push_back(src_mem[i][src_rd[i]]);
          pop_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst) for (int i = 0; i < N; i++) if (rs[i]) src_rd[i]++;
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      done = all_empty() && !vl[vl.size()-1] && (gl[gl.size()-1] == '0);
    end
    chk({tag, "_drain"}, 64'(done), 64'd1);
    chk({tag, "_pop_eq_acc"}, 64'(pop_cnt), 64'(acc_cnt));
  endtask

  task automatic clear_logs();
    gl.delete(); rl.delete(); vl.delete(); ol.delete(); fpl.delete();
    acc_q.delete(); exp_q.delete();
    pop_cnt = 0;
    acc_cnt = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    hold      = '0;
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    tick();
    chk("rst_frame_out", 64'(frame_out), 64'd0);
    chk("rst_frame_last", 64'(frame_last), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_acc(input string tag, input int k, input logic [FW:0] exp);
    chk(tag, 64'(acc_q[k]), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b1;
    hold       = '0;
    fifo_valid = '0;
    fifo_last  = '0;
    frame_in   = '0;
    fp_req     = '1;
    fp_ready   = 1'b1;
    for (int i = 0; i < N; i++) begin
      fp_in[i*FW +: FW] = 32'hF000 + 32'(i);
      src_wr[i] = 0;
      src_rd[i] = 0;
    end

    // Two 3-word frames on sources 1 and 3, round-robin.
    do_reset();
    push(1, 32'hA1, 1'b0); push(1, 32'hA2, 1'b0); push(1, 32'hA3, 1'b1);
    push(3, 32'hC1, 1'b0); push(3, 32'hC2, 1'b0); push(3, 32'hC3, 1'b1);
    repeat (10) tick();
    chk("s1_grant_t0", 64'(gl[0]), 64'd0);
    chk("s1_grant_t1", 64'(gl[1]), 64'b00010);
    chk("s1_rdsel_t1", 64'(rl[1]), 64'b00010);
    chk("s1_valid_t1", 64'(vl[1]), 64'd0);
    chk("s1_valid_t2", 64'(vl[2]), 64'd1);
    chk("s1_grant_t3", 64'(gl[3]), 64'b00010);
    chk("s1_grant_t4", 64'(gl[4]), 64'd0);
    chk("s1_rdsel_t4", 64'(rl[4]), 64'd0);
    chk("s1_gap_t5", 64'(vl[5]), 64'd0);
    chk("s1_grant_t5", 64'(gl[5]), 64'b01000);
    chk("s1_grant_t8", 64'(gl[8]), 64'd0);
    chk("s1_acc_count", 64'(acc_q.size()), 64'd6);
    chk_acc("s1_acc0", 0, 33'h0_000000A1);
    chk_acc("s1_acc1", 1, 33'h0_000000A2);
    chk_acc("s1_acc2", 2, 33'h1_000000A3);
    chk_acc("s1_acc3", 3, 33'h0_000000C1);
    chk_acc("s1_acc4", 4, 33'h0_000000C2);
    chk_acc("s1_acc5", 5, 33'h1_000000C3);
    drain("s1");

    // All sources continuously valid with single-word frames.
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) push(i, 32'(32'h100 * i + k), 1'b1);
    repeat (14) tick();
    chk("s2_grant_t1", 64'(gl[1]), 64'b00001);
    chk("s2_bubble_t2", 64'(gl[2]), 64'd0);
    chk("s2_grant_t3", 64'(gl[3]), 64'b00010);
    chk("s2_grant_t5", 64'(gl[5]), 64'b00100);
    chk("s2_grant_t7", 64'(gl[7]), 64'b01000);
    chk("s2_grant_t9", 64'(gl[9]), 64'b10000);
    chk("s2_grant_t11", 64'(gl[11]), 64'b00001);
    chk_acc("s2_acc0", 0, 33'h0_1_00000000);
    chk_acc("s2_acc1", 1, 33'h1_00000100);
    chk_acc("s2_acc4", 4, 33'h1_00000400);
    chk_acc("s2_acc5", 5, 33'h1_00000001);
    for (int k = 2; k < 12; k++) begin
      chk("s2_fp_alt_or", 64'(fpl[k] | fpl[k+1]), 64'b00001);
      chk("s2_fp_alt_and", 64'(fpl[k] & fpl[k+1]), 64'd0);
    end
    drain("s2");

    // Output back-pressure mid-frame on source 2.
    do_reset();
    push(2, 32'h21, 1'b0); push(2, 32'h22, 1'b0); push(2, 32'h23, 1'b0); push(2, 32'h24, 1'b1);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    for (int k = 3; k < 7; k++) begin
      chk("s3_hold_word", 64'(ol[k]), 64'h22);
      chk("s3_hold_valid", 64'(vl[k]), 64'd1);
      chk("s3_no_pop", 64'(rl[k]), 64'd0);
      chk("s3_grant", 64'(gl[k]), 64'b00100);
    end
    drain("s3");
    chk("s3_acc_count", 64'(acc_q.size()), 64'd4);
    chk_acc("s3_acc0", 0, 33'h0_00000021);
    chk_acc("s3_acc1", 1, 33'h0_00000022);
    chk_acc("s3_acc2", 2, 33'h0_00000023);
    chk_acc("s3_acc3", 3, 33'h1_00000024);

    // Source 0 starves mid-frame while source 4 requests: no preemption.
    do_reset();
    push(0, 32'h01, 1'b0); push(0, 32'h02, 1'b0); push(0, 32'h03, 1'b0); push(0, 32'h04, 1'b1);
    push(4, 32'h41, 1'b0); push(4, 32'h42, 1'b1);
    repeat (3) tick();
    hold[0] = 1'b1;
    repeat (3) tick();
    hold[0] = 1'b0;
    repeat (6) tick();
    for (int k = 3; k < 6; k++) begin
      chk("s4_locked_grant", 64'(gl[k]), 64'b00001);
      chk("s4_stall_no_pop", 64'(rl[k]), 64'd0);
    end
    chk("s4_resume_pop", 64'(rl[6]), 64'b00001);
    chk("s4_grant_t7", 64'(gl[7]), 64'b00001);
    chk("s4_idle_t8", 64'(gl[8]), 64'd0);
    chk("s4_grant_t9", 64'(gl[9]), 64'b10000);
    drain("s4");
    chk("s4_acc_count", 64'(acc_q.size()), 64'd6);
    chk_acc("s4_acc3", 3, 33'h1_00000004);
    chk_acc("s4_acc4", 4, 33'h0_00000041);
    chk_acc("s4_acc5", 5, 33'h1_00000042);

    // Reset during word 2 of a 4-word frame on source 3.
    do_reset();
    push(3, 32'h31, 1'b0); push(3, 32'h32, 1'b0); push(3, 32'h33, 1'b0); push(3, 32'h34, 1'b1);
    repeat (3) tick();
    push(1, 32'h11, 1'b1);
    push(4, 32'h41, 1'b1);
    rst = 1'b1;
    tick();
    chk("s5_rst_out", 64'(ol[3]), 64'd0);
    chk("s5_rst_valid", 64'(vl[3]), 64'd0);
    chk("s5_rst_grant", 64'(gl[3]), 64'd0);
    chk("s5_rst_rdsel", 64'(rl[3]), 64'd0);
    chk("s5_rst_last", 64'(frame_last), 64'd0);
    rst = 1'b0;
    tick();
    chk("s5_idle_t4", 64'(gl[4]), 64'd0);
    chk("s5_src3_pops", 64'(src_rd[3]), 64'd2);
    tick();
    chk("s5_grant_t5", 64'(gl[5]), 64'b00010);
    drain("s5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_arb_mux.md
FRAME_ARB_MUX -- requirements
Module: frame_arb_mux

Interface
REQ-001 Parameter NUM_SW_INST, default 5, number of switch FIFO sources (2..16).
REQ-002 Parameter FRAME_WIDTH, default 32, data word width in bits.
REQ-003 Parameter PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fifo_valid  in  NUM_SW_INST  per-source "word available" (FIFO not empty).
REQ-007 fifo_last  in  NUM_SW_INST  per-source flag: presented word is last of its frame.
REQ-008 frame_in  in  NUM_SW_INST*FRAME_WIDTH  flat-packed source words; source i occupies bits [i*FRAME_WIDTH +: FRAME_WIDTH].
REQ-009 rd_sel  out  NUM_SW_INST  one-hot FIFO pop strobe; bit i high pops source i this cycle.
REQ-010 frame_out  out  FRAME_WIDTH  registered output word.
REQ-011 frame_valid  out  1  frame_out holds a valid word.
REQ-012 frame_last  out  1  frame_out is last word of frame.
REQ-013 out_ready  in  1  downstream accepts frame_out when frame_valid && out_ready.
REQ-014 grant  out  NUM_SW_INST  one-hot registered current owner; all-zero when idle.

Function
REQ-015 FSM states IDLE and BUSY; reset state IDLE.
REQ-016 IDLE: if any fifo_valid set, load grant with arbitration winner and go BUSY next cycle; else stay IDLE, grant = 0.
REQ-017 Round-robin: winner is first requesting index at or above rr_ptr, wrapping modulo NUM_SW_INST; rr_ptr resets to 0.
REQ-018 Fixed priority: winner is lowest requesting index; rr_ptr ignored.
REQ-019 BUSY with owner g: transfer occurs when fifo_valid[g] && (!frame_valid || out_ready); rd_sel[g] = 1 exactly in transfer cycles, otherwise rd_sel = 0.
REQ-020 On transfer, frame_out/frame_last load source g word/last and frame_valid = 1 next cycle.
REQ-021 If frame_valid && out_ready with no transfer, frame_valid clears next cycle; frame_out holds.
REQ-022 If frame_valid && !out_ready, frame_out, frame_last, frame_valid hold unchanged.
REQ-023 Transfer with fifo_last[g] = 1: next state IDLE, grant cleared, rr_ptr = (g+1) mod NUM_SW_INST.
REQ-024 Grant is locked for the whole frame; other sources' fifo_valid never preempt.
REQ-025 fifo_valid[g] low mid-frame: stall in BUSY, no pop, no timeout.
REQ-026 rd_sel is combinational from registered state plus fifo_valid and out_ready; never more than one bit high; never high in IDLE.
REQ-027 Latency: request seen in IDLE at cycle 0 -> grant at cycle 1 -> first pop at cycle 1 -> frame_valid at cycle 2; sustained 1 word/cycle inside a frame with out_ready = 1.
REQ-028 Frame-to-frame gap is exactly one IDLE cycle (arbitration bubble).
REQ-029 Single-word frame (fifo_last on first word) is legal: one pop, return to IDLE.

Reset
REQ-030 On rst: state IDLE, grant = 0, rr_ptr = 0, frame_out = 0, frame_last = 0, frame_valid = 0; rd_sel = 0 while rst is high.
REQ-031 Reset mid-frame abandons the frame; no further pops for it; arbitration restarts from rr_ptr = 0.

Structure
REQ-032 Package frame_mux_pkg holds the FSM state type (IDLE, BUSY) and PRIO_MODE encodings.
REQ-033 Sub-module rr_arbiter (inputs req, ptr, mode; output one-hot winner, purely combinational) holds arbitration logic.

Verification
REQ-034 Sources 1 and 3 each hold a 3-word frame (0xA1..A3, 0xC1..C3), out_ready = 1, round-robin -> output A1,A2,A3 (last on A3), one gap, C1,C2,C3; grant 00010 then 01000.
REQ-035 All 5 sources continuously valid with 1-word frames, round-robin -> grant sequence 0,1,2,3,4,0; fixed priority -> grant always 0.
REQ-036 Source 2 mid-frame, out_ready = 0 for 4 cycles -> frame_out holds, rd_sel = 0 throughout, no word lost or duplicated after release.
REQ-037 Source 0 drops fifo_valid for 3 cycles mid-frame while source 4 valid -> no switch to 4, stall, resume on 0, source 4 granted only after source 0 last word.
REQ-038 Assert rst during word 2 of a 4-word frame -> all outputs 0 next edge, rd_sel = 0, next grant picks lowest requesting index.
REQ-039 Continuous check: $onehot0(rd_sel), $onehot0(grant), rd_sel subset of grant, pop count equals accepted output words.
